banda_mac_sched: RTL

- Time-multiplexed controller for the 3-band biquad filter bank (low/mid/high, each a low-pass section cascaded into a high-pass section).
- Replaces six parallel Filtro instances with one shared signed multiplier and accumulator, sequenced by an FSM.
- Holds all 30 coefficients in a runtime-writable register file, plus per-section delay state.
- Accepts one sample per frame and returns three band outputs.

---
 rtl/banda_mac_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/banda_mac_sched.sv
// Shared-MAC 3-band biquad bank: six sections, 5 MAC + 1 writeback cycle each, out_valid 37 cycles after accept.
// No backpressure: in_valid while busy is dropped and flagged on ovr; coefficient writes only land while idle.
module banda_mac_sched #(
    parameter int sign = 1,
    parameter int pf   = 14,
    parameter int mag  = 7,
    parameter int size = sign + pf + mag
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [size-1:0] u,
    input  logic                   cfg_we,
    input  logic [4:0]             cfg_addr,
    input  logic signed [size-1:0] cfg_data,
    output logic signed [size-1:0] y1,
    output logic signed [size-1:0] y2,
    output logic signed [size-1:0] y3,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   ovr
);
    localparam int NSEC  = 6;
    localparam int NCOEF = 30;
    localparam int PW    = 2 * size;
    localparam int AW    = 2 * size + 3;

    localparam logic signed [size-1:0] B0_ONE = {{(size-pf-1){1'b0}}, 1'b1, {pf{1'b0}}};
    localparam logic signed [AW-1:0]   SAT_HI = {{(AW-size+1){1'b0}}, {(size-1){1'b1}}};
    localparam logic signed [AW-1:0]   SAT_LO = {{(AW-size+1){1'b1}}, {(size-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

    state_t                 state;
    logic [2:0]             sec;
    logic [2:0]             k;
    logic signed [AW-1:0]   acc;
    logic signed [size-1:0] coef [NCOEF];
    logic signed [size-1:0] dx1 [NSEC];
    logic signed [size-1:0] dx2 [NSEC];
    logic signed [size-1:0] dy1 [NSEC];
    logic signed [size-1:0] dy2 [NSEC];
    logic signed [size-1:0] u_lat;
    logic signed [size-1:0] prev_res;
    logic signed [size-1:0] res_low;
    logic signed [size-1:0] res_mid;

    logic [4:0]             cidx;
    logic signed [size-1:0] x_cur;
    logic signed [size-1:0] opnd;
    logic signed [size-1:0] cf;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   acc_sh;
    logic signed [size-1:0] res_sat;

    always_comb begin
        cidx  = 5'(sec) * 5'd5 + 5'(k);
        // Odd sections are the HP half of a band and take the LP result just written back.
        x_cur = sec[0] ? prev_res : u_lat;
        case (k)
            3'd0:    opnd = x_cur;
            3'd1:    opnd = dx1[sec];
            3'd2:    opnd = dx2[sec];
            3'd3:    opnd = dy1[sec];
            3'd4:    opnd = dy2[sec];
            default: opnd = x_cur;
        endcase
        cf       = coef[cidx];
        prod     = $signed({{size{opnd[size-1]}}, opnd}) * $signed({{size{cf[size-1]}}, cf});
        prod_ext = $signed({{(AW-PW){prod[PW-1]}}, prod});
        acc_sh   = acc >>> pf;
        if (acc_sh > SAT_HI) begin
            res_sat = SAT_HI[size-1:0];
        end else if (acc_sh < SAT_LO) begin
            res_sat = SAT_LO[size-1:0];
        end else begin
            res_sat = acc_sh[size-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sec       <= '0;
            k         <= '0;
            acc       <= '0;
            u_lat     <= '0;
            prev_res  <= '0;
            res_low   <= '0;
            res_mid   <= '0;
            y1        <= '0;
            y2        <= '0;
            y3        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ovr       <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                coef[i] <= (i % 5 == 0) ? B0_ONE : '0;
            end
            for (int s = 0; s < NSEC; s++) begin
                dx1[s] <= '0;
                dx2[s] <= '0;
                dy1[s] <= '0;
                dy2[s] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            ovr       <= in_valid && busy;
            case (state)
                IDLE: begin
                    if (cfg_we && !busy && (cfg_addr < 5'd30)) begin
                        coef[cfg_addr] <= cfg_data;
                    end
                    if (in_valid) begin
                        u_lat <= u;
                        sec   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= (k == 3'd0) ? prod_ext : acc + prod_ext;
                    if (k == 3'd4) begin
                        k     <= '0;
                        state <= WB;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                WB: begin
                    dx2[sec] <= dx1[sec];
                    dx1[sec] <= x_cur;
                    dy2[sec] <= dy1[sec];
                    dy1[sec] <= res_sat;
                    prev_res <= res_sat;
                    if (sec == 3'd1) res_low <= res_sat;
                    if (sec == 3'd3) res_mid <= res_sat;
                    if (sec == 3'd5) begin
                        // Outputs register here so they are already valid during DONE.
                        y1        <= res_low;
                        y2        <= res_mid;
                        y3        <= res_sat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sec   <= sec + 3'd1;
                        state <= MAC;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
